// File: rtl/ultra_pkg.sv
// Shared types and constants for the HC-SR04 ultrasonic ranger.
//   state_t    : ranger FSM states (also exported on the debug port)
//   CYC_PER_US : clock cycles per microsecond at the default 100 MHz clock
//   DIST_W     : width of the distance bus feeding the 4-digit FND controller
//   cyc_per_us : same ratio for an arbitrary clock frequency
package ultra_pkg;

  localparam int DEFAULT_CLK_HZ = 100_000_000;
  localparam int CYC_PER_US     = DEFAULT_CLK_HZ / 1_000_000;
  localparam int DIST_W         = 14;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG    = 3'd1,
    WAIT_HI = 3'd2,
    MEASURE = 3'd3,
    DONE    = 3'd4,
    HOLDOFF = 3'd5
  } state_t;

  function automatic int cyc_per_us(input int clk_hz);
    return clk_hz / 1_000_000;
  endfunction

endpackage

// File: rtl/ultra_tick_gen.sv
// One-microsecond tick prescaler.
//   clk   in  system clock
//   reset in  synchronous, active-low reset
//   clr   in  restart the prescaler; the next tick lands exactly DIV cycles later
//   tick  out high for one cycle every DIV cycles
module ultra_tick_gen #(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 front end: fires a trigger pulse, times the echo and converts the
// echo width to centimetres for the downstream 4-digit FND controller.
//   clk         in   system clock
//   reset       in   synchronous, active-low reset
//   start       in   one-shot measurement request, honoured only in IDLE
//   auto        in   1 = re-trigger automatically from IDLE
//   echo        in   sensor echo pin (asynchronous)
//   trig        out  sensor trigger pin
//   distance    out  last good distance in cm, 0..MAX_CM
//   dist_valid  out  one-cycle strobe when distance updates
//   busy        out  high in every state except IDLE
//   err_timeout out  sticky error, cleared by the next good reading or reset
//   dbg_state   out  current FSM state
// Handshake: dist_valid is a pure strobe with no ready/backpressure; distance
// is valid in the strobe cycle and holds its value until the next strobe.
// Build option: define ULTRA_AVG4_EN to output the truncated mean of the last
// four good readings instead of the raw rounded reading.
module ultrasonic_ranger
  import ultra_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TRIG_US     = 10,
  parameter int TIMEOUT_US  = 30000,
  parameter int MAX_ECHO_US = 25000,
  parameter int US_PER_CM   = 58,
  parameter int MAX_CM      = 400,
  parameter int PERIOD_MS   = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              auto,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] distance,
  output logic              dist_valid,
  output logic              busy,
  output logic              err_timeout,
  output state_t            dbg_state
);

  localparam int CYC     = cyc_per_us(CLK_HZ);
  localparam int HOLD_US = PERIOD_MS * 1000;
  localparam int MAX_AB  = (TIMEOUT_US > MAX_ECHO_US) ? TIMEOUT_US : MAX_ECHO_US;
  localparam int MAX_ABC = (MAX_AB > HOLD_US) ? MAX_AB : HOLD_US;
  localparam int US_MAX  = (MAX_ABC > TRIG_US) ? MAX_ABC : TRIG_US;
  localparam int US_W    = $clog2(US_MAX + 1);
  localparam int SUB_W   = $clog2(US_PER_CM + 1);

  localparam logic [US_W-1:0]   TRIG_LAST = US_W'(TRIG_US - 1);
  localparam logic [US_W-1:0]   WAIT_LAST = US_W'(TIMEOUT_US - 1);
  localparam logic [US_W-1:0]   ECHO_LAST = US_W'(MAX_ECHO_US - 1);
  localparam logic [US_W-1:0]   HOLD_LAST = US_W'(HOLD_US - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(US_PER_CM - 1);
  localparam logic [SUB_W-1:0]  SUB_HALF  = SUB_W'(US_PER_CM / 2);
  localparam logic [DIST_W-1:0] CM_MAX    = DIST_W'(MAX_CM);

  state_t state;

  // echo synchroniser and registered edge detector
  logic echo_s1, echo_s2, echo_d, echo_rise, echo_fall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      echo_s1   <= 1'b0;
      echo_s2   <= 1'b0;
      echo_d    <= 1'b0;
      echo_rise <= 1'b0;
      echo_fall <= 1'b0;
    end else begin
      echo_s1   <= echo;
      echo_s2   <= echo_s1;
      echo_d    <= echo_s2;
      echo_rise <= echo_s2 & ~echo_d;
      echo_fall <= ~echo_s2 & echo_d;
    end
  end

  // microsecond tick, restarted whenever the FSM changes state
  logic tick, leave;

  ultra_tick_gen #(.DIV(CYC)) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (leave),
    .tick (tick)
  );

  logic [US_W-1:0]   us_cnt;
  logic [SUB_W-1:0]  sub;
  logic [DIST_W-1:0] cm;

  logic trig_end, wait_to, echo_max, hold_end;
  assign trig_end = tick && (us_cnt == TRIG_LAST);
  assign wait_to  = tick && (us_cnt == WAIT_LAST);
  assign echo_max = tick && (us_cnt == ECHO_LAST);
  assign hold_end = tick && (us_cnt == HOLD_LAST);

  // Auto re-trigger waits for a tick so back-to-back measurements are spaced
  // by an extra microsecond of IDLE; a start request is taken immediately.
  always_comb begin
    leave = 1'b0;
    case (state)
      IDLE:    leave = start | (auto & tick);
      TRIG:    leave = trig_end;
      WAIT_HI: leave = echo_rise | wait_to;
      MEASURE: leave = echo_fall | echo_max;
      DONE:    leave = 1'b1;
      HOLDOFF: leave = hold_end;
      default: leave = 1'b1;
    endcase
  end

  // Centimetre counters including the tick of the current cycle, so the
  // final microsecond of the echo is not lost when the fall is taken.
  logic              sub_wrap, round_up;
  logic [SUB_W-1:0]  sub_nx;
  logic [DIST_W-1:0] cm_nx, cm_rnd, raw_dist, new_dist;

  always_comb begin
    sub_wrap = tick && (sub == SUB_LAST);
    sub_nx   = sub;
    if (tick) sub_nx = sub_wrap ? '0 : sub + 1'b1;
    cm_nx    = (sub_wrap && (cm < CM_MAX)) ? cm + 1'b1 : cm;
    round_up = (sub_nx >= SUB_HALF);
    cm_rnd   = cm_nx + {{(DIST_W-1){1'b0}}, round_up};
    raw_dist = (cm_rnd > CM_MAX) ? CM_MAX : cm_rnd;
  end

`ifdef ULTRA_AVG4_EN
  // h0..h2 hold the three previous good readings (h0 newest)
  logic [DIST_W-1:0] h0, h1, h2;
  logic              h_full;
  logic [DIST_W+1:0] sum4;

  always_comb begin
    sum4     = (DIST_W+2)'(raw_dist) + (DIST_W+2)'(h0) + (DIST_W+2)'(h1) + (DIST_W+2)'(h2);
    new_dist = h_full ? sum4[DIST_W+1:2] : raw_dist;
  end
`else
  assign new_dist = raw_dist;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      trig        <= 1'b0;
      distance    <= '0;
      dist_valid  <= 1'b0;
      err_timeout <= 1'b0;
      us_cnt      <= '0;
      sub         <= '0;
      cm          <= '0;
`ifdef ULTRA_AVG4_EN
      h0          <= '0;
      h1          <= '0;
      h2          <= '0;
      h_full      <= 1'b0;
`endif
    end else begin
      dist_valid <= 1'b0;
      if (leave || state == IDLE) us_cnt <= '0;
      else if (tick)              us_cnt <= us_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (leave) begin
            state <= TRIG;
            trig  <= 1'b1;
          end
        end
        TRIG: begin
          if (trig_end) begin
            state <= WAIT_HI;
            trig  <= 1'b0;
          end
        end
        WAIT_HI: begin
          if (echo_rise) begin
            state <= MEASURE;
            sub   <= '0;
            cm    <= '0;
          end else if (wait_to) begin
            state       <= HOLDOFF;
            err_timeout <= 1'b1;
          end
        end
        MEASURE: begin
          sub <= sub_nx;
          cm  <= cm_nx;
          if (echo_fall) begin
            // result is registered on entry so it is presented during DONE
            state       <= DONE;
            distance    <= new_dist;
            dist_valid  <= 1'b1;
            err_timeout <= 1'b0;
`ifdef ULTRA_AVG4_EN
            if (h_full) begin
              h2 <= h1;
              h1 <= h0;
            end else begin
              h2 <= raw_dist;
              h1 <= raw_dist;
            end
            h0     <= raw_dist;
            h_full <= 1'b1;
`endif
          end else if (echo_max) begin
            state       <= HOLDOFF;
            err_timeout <= 1'b1;
          end
        end
        DONE: begin
          state <= HOLDOFF;
        end
        HOLDOFF: begin
          if (hold_end) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Bench for ultrasonic_ranger with scaled-down timing (2 MHz clock, short
// timeouts and a 1 ms hold-off) so every scenario fits in a short run.
// Expected distances are pushed to exp_q when the echo is driven; a monitor
// pops and compares on every dist_valid strobe.
`timescale 1ns/1ps
module tb_ultrasonic_ranger;
  import ultra_pkg::*;

  localparam int CLK_HZ      = 2_000_000;
  localparam int N           = 2;       // cycles per microsecond
  localparam int TRIG_US     = 10;
  localparam int TIMEOUT_US  = 300;
  localparam int MAX_ECHO_US = 2000;
  localparam int US_PER_CM   = 58;
  localparam int MAX_CM      = 20;
  localparam int PERIOD_MS   = 1;

  logic              clk, reset, start, auto, echo;
  logic              trig, dist_valid, busy, err_timeout;
  logic [DIST_W-1:0] distance;
  state_t            dbg_state;

  ultrasonic_ranger #(
    .CLK_HZ(CLK_HZ), .TRIG_US(TRIG_US), .TIMEOUT_US(TIMEOUT_US),
    .MAX_ECHO_US(MAX_ECHO_US), .US_PER_CM(US_PER_CM), .MAX_CM(MAX_CM),
    .PERIOD_MS(PERIOD_MS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .auto(auto), .echo(echo),
    .trig(trig), .distance(distance), .dist_valid(dist_valid), .busy(busy),
    .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #250 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  logic [DIST_W-1:0] exp_q[$];
  logic [DIST_W-1:0] last_dist = '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

`ifdef ULTRA_AVG4_EN
  logic [DIST_W-1:0] h0, h1, h2;
  bit                h_full = 1'b0;
`endif

  // expected output for a raw rounded reading
  function automatic logic [DIST_W-1:0] model_out(input logic [DIST_W-1:0] raw);
`ifdef ULTRA_AVG4_EN
    logic [DIST_W+1:0] s;
    if (!h_full) begin
      h0 = raw; h1 = raw; h2 = raw; h_full = 1'b1;
      return raw;
    end
    s  = (DIST_W+2)'(raw) + (DIST_W+2)'(h0) + (DIST_W+2)'(h1) + (DIST_W+2)'(h2);
    h2 = h1; h1 = h0; h0 = raw;
    return s[DIST_W+1:2];
`else
    return raw;
`endif
  endfunction

  // scoreboard monitor
  initial begin
    logic [DIST_W-1:0] e;
    forever begin
      @(negedge clk);
      if (dist_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_dist_valid: distance=%0d, no reading expected", distance);
        end else begin
          e = exp_q.pop_front();
          check("distance", int'(distance), int'(e));
        end
      end
    end
  end

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_trig_low(input string name);
    int n = 0;
    while (trig && n < 1000) begin
      wait_cycles(1);
      n++;
    end
    check(name, int'(trig), 0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 20000) begin
      wait_cycles(1);
      n++;
    end
    check(name, int'(busy), 0);
  endtask

  // full measurement; exp_raw < 0 means no result is expected
  task automatic measure(input int delay_us, input int high_us, input int exp_raw);
    int k = 0;
    pulse_start();
    wait_trig_low("trig_end");
    wait_cycles(delay_us * N);
    echo = 1'b1;
    if (exp_raw >= 0) begin
      last_dist = model_out(DIST_W'(exp_raw));
      exp_q.push_back(last_dist);
    end
    wait_cycles(high_us * N);
    echo = 1'b0;
    if (exp_raw >= 0) begin
      while (!dist_valid && k < 10) begin
        wait_cycles(1);
        k++;
      end
      check("valid_latency", k, 4);
    end
    wait_idle("holdoff_end");
  endtask

  // stimulus
  initial begin
    int n, t1, t2;
    reset = 1'b0; start = 1'b0; auto = 1'b0; echo = 1'b0;
    wait_cycles(3);
    check("rst_trig", int'(trig), 0);
    check("rst_distance", int'(distance), 0);
    check("rst_valid", int'(dist_valid), 0);
    check("rst_err", int'(err_timeout), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b1;
    wait_cycles(2);

    // trigger width and busy
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("trig_rise", int'(trig), 1);
    check("busy_rise", int'(busy), 1);
    n = 0;
    while (trig && n < 1000) begin
      wait_cycles(1);
      n++;
    end
    check("trig_width", n, TRIG_US * N);
    wait_cycles(100 * N);
    echo = 1'b1;
    last_dist = model_out(DIST_W'(10));  // 580 us / 58
    exp_q.push_back(last_dist);
    wait_cycles(580 * N);
    echo = 1'b0;
    wait_idle("m1_idle");

    // 609 us = 10.5 cm rounds up
    measure(100, 609, 11);

    // echo never rises
    pulse_start();
    wait_trig_low("to_trig_end");
    wait_cycles(TIMEOUT_US * N - 1);
    check("to_err_before", int'(err_timeout), 0);
    wait_cycles(1);
    check("to_err_set", int'(err_timeout), 1);
    wait_idle("to_idle");
    check("to_dist_held", int'(distance), int'(last_dist));

    // good reading clears the error
    measure(100, 580, 10);
    check("err_cleared", int'(err_timeout), 0);

    // saturation, then echo too long
    measure(50, 1500, MAX_CM);
    measure(50, 2200, -1);
    check("long_err", int'(err_timeout), 1);
    check("long_dist_held", int'(distance), int'(last_dist));

    // reset mid-measurement
    pulse_start();
    wait_trig_low("rst_trig_end");
    wait_cycles(100 * N);
    echo = 1'b1;
    wait_cycles(200 * N);
    check("mid_busy", int'(busy), 1);
    reset = 1'b0;
    wait_cycles(1);
    reset = 1'b1;
    check("mid_rst_trig", int'(trig), 0);
    check("mid_rst_dist", int'(distance), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_err", int'(err_timeout), 0);
`ifdef ULTRA_AVG4_EN
    h_full = 1'b0;
`endif
    last_dist = '0;
    wait_cycles(100 * N);
    echo = 1'b0;
    wait_cycles(20);
    check("mid_stays_idle", int'(busy), 0);

    // auto re-trigger spacing: trig + timeout + hold-off + 1 us of IDLE
    auto = 1'b1;
    n = 0;
    while (!trig && n < 100) begin wait_cycles(1); n++; end
    check("auto_first_trig", int'(trig), 1);
    t1 = cyc;
    n = 0;
    while (trig && n < 1000) begin wait_cycles(1); n++; end
    n = 0;
    while (!trig && n < 10000) begin wait_cycles(1); n++; end
    check("auto_second_trig", int'(trig), 1);
    t2 = cyc;
    check("auto_spacing", t2 - t1, (TRIG_US + TIMEOUT_US + PERIOD_MS * 1000 + 1) * N);
    auto = 1'b0;
    wait_idle("auto_idle");
    check("auto_dist_held", int'(distance), 0);

    wait_cycles(5);
    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog
  initial begin
    #(200_000 * 500);
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
